frame_diff_bbox: RTL and testbench
==================================

# frame_diff_bbox

Consumer of the packed two-frame gray stream ({current, previous} pixel pairs) produced by the frame-delay stage that reads the SDRAM frame buffer. It computes the per-pixel absolute difference and thresholds it into a binary motion mask. It tracks the bounding box of all motion pixels in the frame and reports the box once per frame. The box feeds the overlay/box-drawing logic of the single-moving-object detector.

## Interface
- `IMG_W`, 640: active pixels per line; valid x range is 0..IMG_W-1.
- `IMG_H`, 480: active lines per frame; valid y range is 0..IMG_H-1.

- `clk`  in  1  pixel clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `clken`  in  1  pixel valid; `igray` is meaningful only when high.
- `ivsync`  in  1  frame-active, high for the whole frame.
- `ihsync`  in  1  line-active, high for the whole line.
- `igray`  in  16  [15:8] current-frame gray, [7:0] previous-frame gray.
- `thresh`  in  8  motion threshold, sampled at each frame start.
- `oclken`  out  1  mask pixel valid, aligned with `obin`.
- `obin`  out  1  motion mask, 1 = moving pixel.
- `ovsync`  out  1  `ivsync` delayed 2 cycles.
- `ohsync`  out  1  `ihsync` delayed 2 cycles.
- `box_valid`  out  1  one-cycle pulse when the box outputs update.
- `box_found`  out  1  latched frame contained at least one motion pixel.
- `box_xmin`, `box_xmax`  out  11  latched horizontal box bounds.
- `box_ymin`, `box_ymax`  out  11  latched vertical box bounds.

## Operation
- Reset: every output and internal register is 0, including `primed`, the counters, and the threshold register.
- Stage 1 (registered):
  - `d1 = |igray[15:8] - igray[7:0]|`, 8-bit unsigned, no overflow.
  - Stage 1 registers `clken`, `ivsync`, `ihsync`, and the current x/y coordinates.
- Stage 2 (registered):
  - `obin = primed & clken_d1 & (d1 > thr_q)`; the comparison is strict.
  - `oclken`, `ovsync`, `ohsync` are the stage-2 copies of their inputs.
- Threshold: `thr_q` loads `thresh` on the rising edge of `ivsync` (`ivsync` high, previous `ivsync` low). `thr_q` holds for the whole frame.
- Coordinates:
  - x clears while `ihsync` is low and increments after each `clken` pixel.
  - y clears while `ivsync` is low and increments on each falling edge of `ihsync`.
  - Both counters are 11 bits and saturate at 2047, with no wrap.
  - Pixels with x ≥ IMG_W or y ≥ IMG_H are never merged into the box. They still produce `obin`.
- `primed`:
  - Set on the first falling edge of `ovsync` after reset. That first frame is the one whose previous-frame data is invalid.
  - Stays set until reset.
  - While `primed` = 0: `obin` = 0 and `box_valid` never pulses.
- Box accumulator, driven by stage-2 signals:
  - On a rising edge of `ovsync`, initialise: xmin = IMG_W-1, xmax = 0, ymin = IMG_H-1, ymax = 0, found = 0.
  - On each cycle with `obin` = 1 and in-range coordinates, update xmin/xmax/ymin/ymax by min/max and set found = 1.
  - If initialise and a motion pixel coincide in the same cycle, initialise wins.
- Frame end: on a falling edge of `ovsync` with `primed` already 1, in one cycle:
  - `box_found` ← found.
  - Box outputs ← accumulator if found = 1, else all 0.
  - `box_valid` pulses.
- Box outputs hold between pulses.
- Reset mid-frame: everything clears. The next falling edge of `ovsync` only sets `primed`; the first box is reported one frame later.

## Timing
- `igray` → `obin`: 2 cycles. `oclken`, `ovsync`, `ohsync` carry the same 2-cycle delay.
- `box_valid` rises 1 cycle after the `ovsync` falling edge, i.e. 3 cycles after the `ivsync` falling edge.
- The final pixel of the frame is included if `ivsync` falls no earlier than the cycle after that pixel's `clken`.
- No backpressure; one pixel per clock sustained, with no input stall.
- Minimum frame blanking: 2 cycles of `ivsync` low, so the report does not collide with the next initialise.

## Test plan
- **Reset values:** assert `rst` mid-line → all outputs 0 immediately. After release, the first frame yields no `box_valid` and `obin` stays 0.
- **Single motion pixel:** IMG_W = 8, IMG_H = 4, `thresh` = 30. Frame 2 has a single pixel {100, 50} at (5, 2); all other pixels equal.
  - `obin` = 1 exactly 2 cycles after that pixel.
  - `box_valid` pulses with found = 1 and box (5, 5, 2, 2).
- **Threshold boundary:** diffs of 30 and 31 with `thresh` = 30 → only the 31 pixel sets `obin`.
  - Reversed operands {50, 100} also set `obin` (absolute difference).
- **Multi-pixel box:** motion at (1, 0), (6, 3), (3, 1) → box xmin = 1, xmax = 6, ymin = 0, ymax = 3.
  - Next frame has no motion → `box_found` = 0 and all coordinates 0.
- **Mid-frame threshold change:** change `thresh` mid-frame → no effect until the next `ivsync` rise.
- **Edge pixels:** motion at corner (7, 3) and in the last cycle before `ivsync` falls → included.
  - A `clken` pixel at x = 8 (beyond IMG_W) is excluded from the box.

Source files
------------

// File: rtl/frame_diff_bbox.sv
// Two-frame absolute-difference motion mask with per-frame bounding box; mask latency 2 cycles.
// No backpressure: one pixel per clock, box reported 1 cycle after ovsync falls.
module frame_diff_bbox #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clken,
  input  logic        ivsync,
  input  logic        ihsync,
  input  logic [15:0] igray,
  input  logic [7:0]  thresh,
  output logic        oclken,
  output logic        obin,
  output logic        ovsync,
  output logic        ohsync,
  output logic        box_valid,
  output logic        box_found,
  output logic [10:0] box_xmin,
  output logic [10:0] box_xmax,
  output logic [10:0] box_ymin,
  output logic [10:0] box_ymax
);
  localparam logic [10:0] XLIM  = 11'(IMG_W);
  localparam logic [10:0] YLIM  = 11'(IMG_H);
  localparam logic [10:0] XINIT = 11'(IMG_W - 1);
  localparam logic [10:0] YINIT = 11'(IMG_H - 1);
  localparam logic [10:0] CMAX  = 11'h7FF;

  logic [10:0] x_q, x_d, y_q, y_d, x1_q, y1_q, x2_q, y2_q;
  logic [7:0]  cur, prev, diff_d, d1_q, thr_q;
  logic        clken1_q, vs1_q, hs1_q;
  logic        oclken_q, obin_q, ovs_q, ohs_q, ovs3_q, obin_d;
  logic        ovs_rise, ovs_fall, in_range, primed_q;
  logic        acc_found_q;
  logic [10:0] acc_xmin_q, acc_xmax_q, acc_ymin_q, acc_ymax_q;
  logic        bv_q, bf_q;
  logic [10:0] bxmin_q, bxmax_q, bymin_q, bymax_q;

  always_comb begin
    cur    = igray[15:8];
    prev   = igray[7:0];
    diff_d = (cur >= prev) ? cur - prev : prev - cur;
    x_d = x_q;
    if (!ihsync) x_d = '0;
    else if (clken && x_q != CMAX) x_d = x_q + 11'd1;
    y_d = y_q;
    if (!ivsync) y_d = '0;
    else if (hs1_q && !ihsync && y_q != CMAX) y_d = y_q + 11'd1;
    obin_d   = primed_q & clken1_q & (d1_q > thr_q);
    ovs_rise = ovs_q & ~ovs3_q;
    ovs_fall = ~ovs_q & ovs3_q;
    in_range = (x2_q < XLIM) && (y2_q < YLIM);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= '0; y_q <= '0; x1_q <= '0; y1_q <= '0; x2_q <= '0; y2_q <= '0;
      d1_q <= '0; thr_q <= '0; clken1_q <= 1'b0; vs1_q <= 1'b0; hs1_q <= 1'b0;
      oclken_q <= 1'b0; obin_q <= 1'b0; ovs_q <= 1'b0; ohs_q <= 1'b0; ovs3_q <= 1'b0;
      primed_q <= 1'b0; acc_found_q <= 1'b0;
      acc_xmin_q <= '0; acc_xmax_q <= '0; acc_ymin_q <= '0; acc_ymax_q <= '0;
      bv_q <= 1'b0; bf_q <= 1'b0;
      bxmin_q <= '0; bxmax_q <= '0; bymin_q <= '0; bymax_q <= '0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      d1_q     <= diff_d;
      clken1_q <= clken;
      vs1_q    <= ivsync;
      hs1_q    <= ihsync;
      x1_q     <= x_q;
      y1_q     <= y_q;
      if (ivsync && !vs1_q) thr_q <= thresh;
      obin_q   <= obin_d;
      oclken_q <= clken1_q;
      ovs_q    <= vs1_q;
      ohs_q    <= hs1_q;
      x2_q     <= x1_q;
      y2_q     <= y1_q;
      ovs3_q   <= ovs_q;
      // Initialise takes priority over a coincident motion pixel.
      if (ovs_rise) begin
        acc_found_q <= 1'b0;
        acc_xmin_q  <= XINIT;
        acc_xmax_q  <= '0;
        acc_ymin_q  <= YINIT;
        acc_ymax_q  <= '0;
      end else if (obin_q && in_range) begin
        acc_found_q <= 1'b1;
        acc_xmin_q  <= (x2_q < acc_xmin_q) ? x2_q : acc_xmin_q;
        acc_xmax_q  <= (x2_q > acc_xmax_q) ? x2_q : acc_xmax_q;
        acc_ymin_q  <= (y2_q < acc_ymin_q) ? y2_q : acc_ymin_q;
        acc_ymax_q  <= (y2_q > acc_ymax_q) ? y2_q : acc_ymax_q;
      end
      bv_q <= 1'b0;
      if (ovs_fall) begin
        primed_q <= 1'b1;
        if (primed_q) begin
          bv_q    <= 1'b1;
          bf_q    <= acc_found_q;
          bxmin_q <= acc_found_q ? acc_xmin_q : '0;
          bxmax_q <= acc_found_q ? acc_xmax_q : '0;
          bymin_q <= acc_found_q ? acc_ymin_q : '0;
          bymax_q <= acc_found_q ? acc_ymax_q : '0;
        end
      end
    end
  end

  assign oclken    = oclken_q;
  assign obin      = obin_q;
  assign ovsync    = ovs_q;
  assign ohsync    = ohs_q;
  assign box_valid = bv_q;
  assign box_found = bf_q;
  assign box_xmin  = bxmin_q;
  assign box_xmax  = bxmax_q;
  assign box_ymin  = bymin_q;
  assign box_ymax  = bymax_q;
endmodule

// File: tb/tb_frame_diff_bbox.sv
// Scoreboard bench for frame_diff_bbox: random and directed frames on an 8x4 image.
module tb_frame_diff_bbox;
  localparam int W = 8;
  localparam int H = 4;

  logic        clk = 1'b0, rst = 1'b1, clken = 1'b0, ivsync = 1'b0, ihsync = 1'b0;
  logic [15:0] igray = '0;
  logic [7:0]  thresh = '0;
  logic        oclken, obin, ovsync, ohsync, box_valid, box_found;
  logic [10:0] box_xmin, box_xmax, box_ymin, box_ymax;

  frame_diff_bbox #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .clken(clken), .ivsync(ivsync), .ihsync(ihsync),
    .igray(igray), .thresh(thresh), .oclken(oclken), .obin(obin),
    .ovsync(ovsync), .ohsync(ohsync), .box_valid(box_valid), .box_found(box_found),
    .box_xmin(box_xmin), .box_xmax(box_xmax), .box_ymin(box_ymin), .box_ymax(box_ymax)
  );

  always #5 clk = ~clk;

  typedef struct { bit b; int t; } exp_pix_t;
  typedef struct { bit f; int x0; int x1; int y0; int y1; } exp_box_t;

  exp_pix_t pq[$];
  exp_box_t bq[$];
  exp_pix_t ep;
  exp_box_t eb;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit mon_en = 0;
  bit primed_m = 0;
  int thr_f;
  int cur_m[H][W+1];
  int prv_m[H][W+1];
  bit bf;
  int bx0, bx1, by0, by1;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every mask pixel and every box report is matched against the queues.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (oclken) begin
        tests++;
        if (pq.size() == 0) begin
          fails++;
          $display("FAIL obin_extra: got obin=%0b with no pixel pending", obin);
        end else begin
          ep = pq.pop_front();
          if (obin !== ep.b || (cyc - ep.t) != 2) begin
            fails++;
            $display("FAIL obin: got %0b latency %0d, want %0b latency 2", obin, cyc - ep.t, ep.b);
          end
        end
      end
      if (box_valid) begin
        tests++;
        if (bq.size() == 0) begin
          fails++;
          $display("FAIL box_extra: box_valid with no report expected (found=%0b)", box_found);
        end else begin
          eb = bq.pop_front();
          if (box_found !== eb.f || box_xmin !== 11'(eb.x0) || box_xmax !== 11'(eb.x1) ||
              box_ymin !== 11'(eb.y0) || box_ymax !== 11'(eb.y1)) begin
            fails++;
            $display("FAIL box: got f=%0b x=%0d..%0d y=%0d..%0d, want f=%0b x=%0d..%0d y=%0d..%0d",
                     box_found, box_xmin, box_xmax, box_ymin, box_ymax,
                     eb.f, eb.x0, eb.x1, eb.y0, eb.y1);
          end
        end
      end
    end
  end

  task automatic check_zero(input string name);
    tests++;
    if ({oclken, obin, ovsync, ohsync, box_valid, box_found,
         box_xmin, box_xmax, box_ymin, box_ymax} !== '0) begin
      fails++;
      $display("FAIL %s: got oclken=%0b obin=%0b ovs=%0b ohs=%0b bv=%0b bf=%0b x=%0d..%0d y=%0d..%0d, want all 0",
               name, oclken, obin, ovsync, ohsync, box_valid, box_found,
               box_xmin, box_xmax, box_ymin, box_ymax);
    end
  endtask

  task automatic check_drained(input string name);
    tests++;
    if (pq.size() != 0 || bq.size() != 0) begin
      fails++;
      $display("FAIL %s: pixels pending %0d, boxes pending %0d, want 0 and 0", name, pq.size(), bq.size());
    end
  endtask

  task automatic fill(input int motion_div);
    for (int y = 0; y < H; y++)
      for (int x = 0; x <= W; x++) begin
        prv_m[y][x] = $urandom_range(0, 255);
        cur_m[y][x] = prv_m[y][x];
        if (motion_div > 0 && $urandom_range(0, motion_div - 1) == 0)
          cur_m[y][x] = $urandom_range(0, 255);
      end
  endtask

  task automatic setp(input int x, input int y, input int c, input int p);
    cur_m[y][x] = c;
    prv_m[y][x] = p;
  endtask

  task automatic pix(input int x, input int y);
    int c, p, d;
    bit mot;
    exp_pix_t e;
    c = cur_m[y][x];
    p = prv_m[y][x];
    d = (c > p) ? c - p : p - c;
    mot = primed_m && (d > thr_f);
    clken = 1'b1;
    igray = {8'(c), 8'(p)};
    e.b = mot;
    e.t = cyc;
    pq.push_back(e);
    if (mot && x < W && y < H) begin
      bf = 1'b1;
      if (x < bx0) bx0 = x;
      if (x > bx1) bx1 = x;
      if (y < by0) by0 = y;
      if (y > by1) by1 = y;
    end
    @(negedge clk);
  endtask

  // One frame: threshold taken at frame start; optional mid-frame threshold change,
  // an extra out-of-range pixel at x=W on line 0, and a frame that ends right after its last pixel.
  task automatic frame(input int thr, input int mid_thr, input bit x8, input bit tight);
    exp_box_t b;
    thr_f = thr;
    thresh = 8'(thr);
    bf = 1'b0; bx0 = W - 1; bx1 = 0; by0 = H - 1; by1 = 0;
    ivsync = 1'b1; ihsync = 1'b0; clken = 1'b0;
    @(negedge clk);
    for (int y = 0; y < H; y++) begin
      ihsync = 1'b1;
      for (int x = 0; x < W + ((x8 && y == 0) ? 1 : 0); x++) pix(x, y);
      if (mid_thr >= 0 && y == 1) thresh = 8'(mid_thr);
      if (!(tight && y == H - 1)) begin
        clken = 1'b0; ihsync = 1'b0;
        repeat (2) @(negedge clk);
      end
    end
    ivsync = 1'b0; ihsync = 1'b0; clken = 1'b0; igray = '0;
    if (primed_m) begin
      b.f = bf;
      b.x0 = bf ? bx0 : 0; b.x1 = bf ? bx1 : 0;
      b.y0 = bf ? by0 : 0; b.y1 = bf ? by1 : 0;
      bq.push_back(b);
    end
    primed_m = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within 50000 cycles");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_zero("reset_init");
    rst = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    // Unprimed first frame: lots of motion, but no mask and no report.
    fill(2);                                    frame(30, -1, 0, 0);
    fill(0); setp(5, 2, 100, 50);               frame(30, -1, 0, 0);
    fill(0); setp(0, 0, 80, 50); setp(2, 1, 81, 50); setp(4, 3, 50, 100);
                                                frame(30, -1, 0, 0);
    fill(0); setp(1, 0, 200, 10); setp(6, 3, 200, 10); setp(3, 1, 10, 200);
                                                frame(30, -1, 0, 0);
    fill(0);                                    frame(30, -1, 0, 0);
    fill(0); setp(6, 0, 150, 100); setp(2, 2, 150, 100);
                                                frame(30, 200, 0, 0);
    fill(0); setp(1, 1, 150, 100); setp(3, 2, 230, 10);
                                                frame(200, -1, 0, 0);
    fill(0); setp(8, 0, 255, 0); setp(2, 1, 0, 90); setp(7, 3, 200, 0);
                                                frame(30, -1, 1, 1);
    for (int i = 0; i < 8; i++) begin
      fill(8);
      frame($urandom_range(0, 120), -1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    repeat (6) @(negedge clk);
    check_drained("drain_before_reset");

    // Reset in the middle of a line.
    mon_en = 1'b0;
    ivsync = 1'b1; thresh = 8'd5;
    @(negedge clk);
    ihsync = 1'b1;
    for (int i = 0; i < 3; i++) begin
      clken = 1'b1; igray = 16'($urandom);
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    check_zero("reset_midline");
    clken = 1'b0; ivsync = 1'b0; ihsync = 1'b0; igray = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    primed_m = 1'b0;
    mon_en = 1'b1;
    fill(2);                                    frame(30, -1, 0, 0);
    fill(0); setp(0, 3, 9, 200); setp(4, 0, 120, 60);
                                                frame(30, -1, 0, 0);
    repeat (6) @(negedge clk);
    check_drained("drain_final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
